// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes one character per valid/ready handshake and
// shifts out start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits.
module uart_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BAUD_TICK,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic [1:0]        WLS,
  input  logic              PEN,
  input  logic              EPS,
  input  logic              STB,
  output logic              TXD,
  output logic              BUSY,
  output logic [2:0]        STATE
);

  localparam int TCW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCW = $clog2(DATA_W);
  localparam logic [TCW-1:0] TICK_FULL = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] TICK_HALF = TCW'(OVERSAMPLE / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        r_state;
  logic              r_txd;
  logic              r_busy;
  logic [TCW-1:0]    r_tick;
  logic [BCW-1:0]    r_bit_cnt;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_wls;
  logic              r_pen;
  logic              r_eps;
  logic              r_stb;

  logic              w_accept;
  logic              w_half_stop;
  logic              w_bit_end;
  logic [TCW-1:0]    w_tick_limit;
  logic [BCW-1:0]    w_last_idx;
  logic [BCW-1:0]    w_next_idx;

  // Bits above the active word length are masked out before the XOR.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d,
                                      input logic [1:0]        wls,
                                      input logic              eps);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b1}} >> (2'd3 - wls);
    return (^(d & mask)) ^ ~eps;
  endfunction

  assign TX_READY     = (r_state == S_IDLE);
  assign w_accept     = TX_VALID & TX_READY;
  assign w_last_idx   = BCW'(4) + BCW'(r_wls);
  assign w_next_idx   = r_bit_cnt + BCW'(1);
  // Second stop bit of a 5-bit word is only half a bit period (1.5 stop bits).
  assign w_half_stop  = (r_state == S_STOP) && (r_bit_cnt == BCW'(1)) && (r_wls == 2'd0);
  assign w_tick_limit = w_half_stop ? TICK_HALF : TICK_FULL;
  assign w_bit_end    = BAUD_TICK && (r_tick == w_tick_limit);

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_data <= TX_DATA;
      r_wls  <= WLS;
      r_pen  <= PEN;
      r_eps  <= EPS;
      r_stb  <= STB;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_tick    <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (TX_VALID) begin
        r_state   <= S_START;
        r_txd     <= 1'b0;
        r_busy    <= 1'b1;
        r_tick    <= '0;
        r_bit_cnt <= '0;
      end
    end else if (BAUD_TICK) begin
      if (!w_bit_end) begin
        r_tick <= r_tick + TCW'(1);
      end else begin
        r_tick <= '0;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_txd     <= r_data[0];
            r_bit_cnt <= '0;
          end
          S_DATA: begin
            if (r_bit_cnt != w_last_idx) begin
              r_bit_cnt <= w_next_idx;
              r_txd     <= r_data[w_next_idx];
            end else begin
              r_bit_cnt <= '0;
              if (r_pen) begin
                r_state <= S_PARITY;
                r_txd   <= parity_bit(r_data, r_wls, r_eps);
              end else begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end
          S_STOP: begin
            r_txd <= 1'b1;
            if ((r_bit_cnt == '0) && r_stb) begin
              r_bit_cnt <= BCW'(1);
            end else begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign TXD   = r_txd;
  assign BUSY  = r_busy;
  assign STATE = r_state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame formats, baud pacing, stalls,
// mid-frame reset and back-to-back handshakes with hand-derived waveforms.
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BAUD_TICK;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic [1:0] WLS;
  logic       PEN;
  logic       EPS;
  logic       STB;
  wire        TX_READY;
  wire        TXD;
  wire        BUSY;
  wire  [2:0] STATE;

  int tests = 0;
  int fails = 0;

  logic       cap_txd  [0:4095];
  logic [2:0] cap_st   [0:4095];
  logic       cap_busy [0:4095];

  uart_tx_serializer #(.DATA_W(8), .OVERSAMPLE(16)) dut (
    .CLK(CLK), .RST(RST), .BAUD_TICK(BAUD_TICK), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .WLS(WLS), .PEN(PEN),
    .EPS(EPS), .STB(STB), .TXD(TXD), .BUSY(BUSY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2ms", $time);
    $fatal(1);
  end

  // Presents a character from IDLE and waits (bounded) for STATE to show START.
  task automatic send(input logic [7:0] d, input logic [1:0] w, input logic p,
                      input logic e, input logic s, input bit hold, output bit ok);
    TX_DATA = d; WLS = w; PEN = p; EPS = e; STB = s;
    TX_VALID = 1'b1; BAUD_TICK = 1'b0; ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge CLK); #1;
      if (STATE == 3'd1) ok = 1'b1;
    end
    if (!hold) TX_VALID = 1'b0;
  endtask

  // Records TXD/STATE/BUSY once per cycle after acceptance until STATE is IDLE.
  // Drives BAUD_TICK every div cycles, with an optional stall window, an optional
  // mid-frame input change and an optional reset pulse.
  task automatic capture(input int div, input int frz_at, input int frz_len,
                         input int chg_at, input logic [7:0] chg_d, input logic [1:0] chg_w,
                         input int rst_at, output int ncyc, output bit tmo);
    int tcnt;
    tcnt = 0; ncyc = 0; tmo = 1'b0;
    while (STATE != 3'd0) begin
      cap_txd[ncyc] = TXD; cap_st[ncyc] = STATE; cap_busy[ncyc] = BUSY;
      if (ncyc == chg_at) begin TX_DATA = chg_d; WLS = chg_w; end
      if (ncyc == rst_at) RST = 1'b1;
      if (frz_at >= 0 && ncyc >= frz_at && ncyc < frz_at + frz_len) begin
        BAUD_TICK = 1'b0;
      end else begin
        BAUD_TICK = ((tcnt % div) == 0);
        tcnt++;
      end
      ncyc++;
      if (ncyc >= 4000) begin tmo = 1'b1; break; end
      @(posedge CLK); #1;
    end
    BAUD_TICK = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; TX_VALID = 1'b1; TX_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (STATE !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d, required 0", STATE); end
    tests++; if (TXD !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b, required 1", TXD); end
    tests++; if (TX_READY !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", TX_READY); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", BUSY); end
    TX_VALID = 1'b0; RST = 1'b0;
    @(posedge CLK); #1;
    tests++; if (STATE !== 3'd0) begin fails++; $display("FAIL reset_no_accept: got state %0d, required 0", STATE); end
  endtask

  task automatic test_formats;
    logic [7:0]  d;
    logic [1:0]  w;
    logic        p, e, s;
    logic [0:11] lv;
    int          nexp, n, bad, first;
    bit          ok, tmo;
    string       nm;
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: begin nm = "8N1"; d = 8'h55; w = 2'd3; p = 0; e = 0; s = 0; nexp = 160; lv = 12'b010101010100; end
        1: begin nm = "7E1"; d = 8'h87; w = 2'd2; p = 1; e = 1; s = 0; nexp = 160; lv = 12'b011100001100; end
        2: begin nm = "7O1"; d = 8'h87; w = 2'd2; p = 1; e = 0; s = 0; nexp = 160; lv = 12'b011100000100; end
        3: begin nm = "5N2"; d = 8'h1F; w = 2'd0; p = 0; e = 0; s = 1; nexp = 120; lv = 12'b011111110000; end
        default: begin nm = "8N2"; d = 8'h55; w = 2'd3; p = 0; e = 0; s = 1; nexp = 176; lv = 12'b010101010110; end
      endcase
      send(d, w, p, e, s, 1'b0, ok);
      tests++; if (!ok) begin fails++; $display("FAIL %s_accept: got state %0d, required 1", nm, STATE); end
      capture(1, -1, 0, -1, 8'h00, 2'd0, -1, n, tmo);
      tests++; if (tmo || n != nexp) begin fails++; $display("FAIL %s_frame_len: got %0d cycles, required %0d", nm, n, nexp); end
      bad = 0; first = -1;
      for (int c = 0; c < nexp; c++) begin
        if (cap_txd[c] !== lv[c / 16]) begin bad++; if (first < 0) first = c; end
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL %s_txd: %0d wrong cycles, first at %0d got %b required %b", nm, bad, first, cap_txd[first], lv[first / 16]); end
      tests++; if (cap_st[0] !== 3'd1 || cap_st[16] !== 3'd2 || cap_st[nexp-1] !== 3'd4) begin
        fails++; $display("FAIL %s_states: got %0d,%0d,%0d required 1,2,4", nm, cap_st[0], cap_st[16], cap_st[nexp-1]);
      end
      if (p) begin
        tests++; if (cap_st[136] !== 3'd3) begin fails++; $display("FAIL %s_parity_state: got %0d, required 3", nm, cap_st[136]); end
      end
      bad = 0;
      for (int c = 0; c < nexp; c++) if (cap_busy[c] !== 1'b1) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL %s_busy: low on %0d cycles, required 0", nm, bad); end
      tests++; if (TX_READY !== 1'b1 || BUSY !== 1'b0 || TXD !== 1'b1) begin
        fails++; $display("FAIL %s_end: got ready=%b busy=%b txd=%b required 1,0,1", nm, TX_READY, BUSY, TXD);
      end
    end
    bad = 0;
    for (int c = 0; c < 160; c++) ;
  endtask

  task automatic test_slow_tick;
    int  n, runs, len, bad;
    int  rl [0:15];
    bit  ok, tmo;
    send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL slow_accept: got state %0d, required 1", STATE); end
    capture(4, -1, 0, -1, 8'h00, 2'd0, -1, n, tmo);
    tests++; if (tmo || n != 637) begin fails++; $display("FAIL slow_frame_len: got %0d cycles, required 637", n); end
    runs = 0; len = 1;
    for (int c = 1; c <= n && c < 4000; c++) begin
      if (c == n || cap_txd[c] !== cap_txd[c-1]) begin
        if (runs < 16) rl[runs] = len;
        runs++; len = 1;
      end else begin
        len++;
      end
    end
    tests++; if (runs != 10) begin fails++; $display("FAIL slow_runs: got %0d levels, required 10", runs); end
    if (runs == 10) begin
      tests++; if (rl[0] != 61) begin fails++; $display("FAIL slow_start_len: got %0d cycles, required 61", rl[0]); end
      bad = 0;
      for (int r = 1; r < 10; r++) if (rl[r] != 64) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL slow_bit_len: %0d bits not 64 cycles, required 0", bad); end
    end
  endtask

  task automatic test_freeze;
    logic [0:9] lv;
    int         n, bad, first;
    bit         ok, tmo;
    lv = 10'b0101010101;
    send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL freeze_accept: got state %0d, required 1", STATE); end
    capture(1, 40, 100, -1, 8'h00, 2'd0, -1, n, tmo);
    tests++; if (tmo || n != 260) begin fails++; $display("FAIL freeze_frame_len: got %0d cycles, required 260", n); end
    bad = 0; first = -1;
    for (int c = 40; c <= 140; c++) begin
      if (cap_txd[c] !== 1'b0 || cap_st[c] !== 3'd2) begin bad++; if (first < 0) first = c; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL freeze_hold: %0d cycles moved, first at %0d got txd=%b state=%0d required 0,2", bad, first, cap_txd[first], cap_st[first]); end
    bad = 0;
    for (int c = 141; c < 260; c++) if (cap_txd[c] !== lv[(c - 100) / 16]) bad++;
    for (int c = 0; c < 40; c++) if (cap_txd[c] !== lv[c / 16]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL freeze_resume: %0d wrong cycles, required 0", bad); end
  endtask

  task automatic test_reset_midframe;
    logic [0:9] lv;
    int         n, bad;
    bit         ok, tmo;
    send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_accept: got state %0d, required 1", STATE); end
    capture(1, -1, 0, -1, 8'h00, 2'd0, 70, n, tmo);
    tests++; if (n != 71 || cap_txd[70] !== 1'b0 || cap_st[70] !== 3'd2) begin
      fails++; $display("FAIL rstmid_before: got n=%0d txd=%b state=%0d required 71,0,2", n, cap_txd[70], cap_st[70]);
    end
    tests++; if (TXD !== 1'b1 || STATE !== 3'd0 || TX_READY !== 1'b1 || BUSY !== 1'b0) begin
      fails++; $display("FAIL rstmid_after: got txd=%b state=%0d ready=%b busy=%b required 1,0,1,0", TXD, STATE, TX_READY, BUSY);
    end
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (STATE !== 3'd0 || TXD !== 1'b1) begin fails++; $display("FAIL rstmid_no_retx: got state=%0d txd=%b required 0,1", STATE, TXD); end
    lv = 10'b0101001011;
    send(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_a5_accept: got state %0d, required 1", STATE); end
    capture(1, -1, 0, -1, 8'h00, 2'd0, -1, n, tmo);
    tests++; if (tmo || n != 160) begin fails++; $display("FAIL rstmid_a5_len: got %0d cycles, required 160", n); end
    bad = 0;
    for (int c = 0; c < 160; c++) if (cap_txd[c] !== lv[c / 16]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_a5_txd: %0d wrong cycles, required 0", bad); end
  endtask

  task automatic test_back_to_back;
    logic [0:9] lv1;
    logic [0:6] lv2;
    int         n, bad;
    bit         ok, tmo;
    lv1 = 10'b0111100001;
    lv2 = 7'b0001111;
    send(8'h0F, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_accept: got state %0d, required 1", STATE); end
    capture(1, -1, 0, 20, 8'h3C, 2'd0, -1, n, tmo);
    tests++; if (tmo || n != 160) begin fails++; $display("FAIL b2b_first_len: got %0d cycles, required 160", n); end
    bad = 0;
    for (int c = 0; c < 160; c++) if (cap_txd[c] !== lv1[c / 16]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_first_txd: %0d wrong cycles, required 0", bad); end
    tests++; if (STATE !== 3'd0 || TXD !== 1'b1) begin fails++; $display("FAIL b2b_gap: got state=%0d txd=%b required 0,1", STATE, TXD); end
    @(posedge CLK); #1;
    tests++; if (STATE !== 3'd1 || TXD !== 1'b0) begin fails++; $display("FAIL b2b_second_accept: got state=%0d txd=%b required 1,0", STATE, TXD); end
    TX_VALID = 1'b0;
    capture(1, -1, 0, -1, 8'h00, 2'd0, -1, n, tmo);
    tests++; if (tmo || n != 112) begin fails++; $display("FAIL b2b_second_len: got %0d cycles, required 112", n); end
    bad = 0;
    for (int c = 0; c < 112; c++) if (cap_txd[c] !== lv2[c / 16]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_second_txd: %0d wrong cycles, required 0", bad); end
  endtask

  initial begin
    RST = 1'b1; BAUD_TICK = 1'b0; TX_DATA = 8'h00; TX_VALID = 1'b0;
    WLS = 2'd3; PEN = 1'b0; EPS = 1'b0; STB = 1'b0;
    test_reset;
    test_formats;
    test_slow_tick;
    test_freeze;
    test_reset_midframe;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit serializer stage of the UART 16750 datapath. Sits directly downstream of the TX FIFO/THR.
- Accepts one character per valid/ready handshake and shifts it onto TXD as a frame: start bit, 5–8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from an external 16x baud enable. The FSM state is exported for the interrupt and status logic (TEMT/THRE).

Parameters:
- DATA_W, 8, maximum character width. The active width is selected by WLS; DATA_W is fixed at 8 in this design.
- OVERSAMPLE, 16, BAUD_TICK pulses per bit period. Legal values are 2..256.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous reset, active-high
- BAUD_TICK  input  1  single-cycle enable, OVERSAMPLE pulses per bit
- TX_DATA  input  DATA_W  character to send
- TX_VALID  input  1  TX_DATA is valid
- TX_READY  output  1  serializer can accept a character
- WLS  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits
- PEN  input  1  parity enable
- EPS  input  1  1=even parity, 0=odd parity
- STB  input  1  0=one stop bit, 1=two stop bits
- TXD  output  1  serial output; idle level is 1
- BUSY  output  1  a frame is in progress
- STATE  output  3  FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4

Behaviour:
- Reset values: STATE=IDLE, TXD=1, TX_READY=1, BUSY=0, all counters 0. TXD, BUSY and STATE are registered.
- Reset has priority over every other event. RST asserted mid-frame aborts the frame:
  - TXD returns to 1 on that edge;
  - the character is discarded and is not retransmitted.
- Handshake:
  - TX_READY = (STATE==IDLE), driven combinationally from the state register.
  - Acceptance occurs on an edge where TX_VALID & TX_READY.
  - TX_VALID while busy is ignored; the upstream stage must hold data until accepted.
- On acceptance, all of the following happen on that same edge:
  - TX_DATA, WLS, PEN, EPS and STB are latched;
  - the tick counter clears;
  - the bit counter clears;
  - STATE becomes START, TXD becomes 0, BUSY becomes 1.
- Config inputs changing mid-frame have no effect on the current frame.
- Bit timing:
  - The tick counter increments only on BAUD_TICK.
  - A bit period ends on the edge where BAUD_TICK=1 and the counter equals OVERSAMPLE-1; the counter then wraps to 0.
  - With no BAUD_TICK, the FSM holds its state and TXD indefinitely.
- Transitions, each taken at bit-period end:
  - START -> DATA, TXD = data[0].
  - DATA, bit counter < len-1 -> DATA, next data bit on TXD, LSB first.
  - DATA, last bit -> PARITY if PEN, else STOP.
  - PARITY -> STOP, TXD=1.
  - STOP -> IDLE after the configured stop bits, TXD stays 1.
- Parity value: XOR of the len active bits, XNOR-ed with EPS' inverse, i.e. even => XOR, odd => ~XOR. Bits above len are ignored.
- Stop bits:
  - STB=0: one stop bit.
  - STB=1: two stop bits. For WLS=0 (5-bit words) the second stop bit lasts OVERSAMPLE/2 ticks, giving 1.5 stop bits per the 16550 rule.
- End of frame: BUSY falls with the entry to IDLE.
- Back-to-back frames: a character presented while in IDLE is accepted on the first edge in IDLE. The gap between frames is therefore one CLK cycle of idle-high TXD, independent of BAUD_TICK.
- Frame length in ticks = (1 + len + PEN + stops) × OVERSAMPLE.

Test Plan:
- 8N1, BAUD_TICK held at 1, OVERSAMPLE=16, TX_DATA=0x55:
  - TXD = 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles;
  - STATE sequence 1,2,…,4,0;
  - TX_READY reasserts 160 cycles after acceptance.
- 7E1, TX_DATA=0x87 → data 1,1,1,0,0,0,0 then parity bit 1 (bit 7 ignored). Same data as 7O1 → parity bit 0. Frame is 160 ticks.
- 5N2, TX_DATA=0x1F → data 1,1,1,1,1 then stop high for 16+8 ticks; 1.5-stop frame is 7.5×16=120 ticks. 8N2 → stop high for 32 ticks.
- BAUD_TICK pulsed every 4th cycle, 8N1 → each bit lasts 64 CLK cycles. Holding BAUD_TICK low for 100 cycles mid-data freezes TXD and STATE.
- RST pulsed during DATA bit 3 → next edge TXD=1, STATE=0, TX_READY=1, BUSY=0. A new 0xA5 afterwards transmits as a complete, correct frame.
- TX_VALID held high with two characters queued:
  - the second is accepted exactly 1 cycle after STATE returns to IDLE;
  - TX_DATA changes while BUSY do not corrupt the frame in flight.
